// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_pkg                                                        |
// | Purpose  : Shared UART definitions: FSM state encodings, data width and    |
// |            the clocks-per-bit helper used by both receiver and transmitter.|
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   // 3-bit state encodings shared by the UART state machines
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } uart_state_e;

   // Number of system clocks per serial bit (truncating division)
   function automatic int uart_clks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx_if                                                      |
// | Purpose  : Bundles the receiver's serial input and host-side outputs.      |
// |            master = receiver (uart_rx), slave = line driver / host side.   |
// | Signals  : rx_line   serial input, idle high                               |
// |            data      last correctly received byte                          |
// |            rx_valid  one-cycle strobe, data updated in the same cycle      |
// |            rx_busy   high while a frame is in progress                     |
// |            frame_err one-cycle strobe on a low stop bit                    |
// |            parity_err one-cycle strobe on bad even parity                  |
// |                      (only with UART_RX_PARITY_EN defined)                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface uart_rx_if;
   import uart_pkg::*;

   logic                      rx_line;
   logic [UART_DATA_BITS-1:0] data;
   logic                      rx_valid;
   logic                      rx_busy;
   logic                      frame_err;
`ifdef UART_RX_PARITY_EN
   logic                      parity_err;
`endif

`ifdef UART_RX_PARITY_EN
   modport master (input rx_line, output data, output rx_valid, output rx_busy,
                   output frame_err, output parity_err);
   modport slave  (output rx_line, input data, input rx_valid, input rx_busy,
                   input frame_err, input parity_err);
`else
   modport master (input rx_line, output data, output rx_valid, output rx_busy,
                   output frame_err);
   modport slave  (output rx_line, input data, input rx_valid, input rx_busy,
                   input frame_err);
`endif

endinterface
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_sync2                                                      |
// | Purpose  : Two-flop synchroniser for a single asynchronous input. Resets   |
// |            to 1 so an idle-high line does not look like an edge.           |
// | Ports    : clk   system clock, rising edge                                 |
// |            reset asynchronous, active-high                                 |
// |            d_i   asynchronous input                                        |
// |            q_o   synchronised output                                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx                                                         |
// | Purpose  : Asynchronous serial receiver, 8N1 LSB first (8E1 with           |
// |            UART_RX_PARITY_EN defined). Synchronises the line, validates    |
// |            the start bit at mid-bit, samples each bit at mid-bit, checks   |
// |            the stop bit and strobes each good byte for one cycle.          |
// | Params   : CLK_FREQ  system clock in Hz                                    |
// |            BAUD_RATE serial bit rate                                       |
// | Ports    : clk   system clock, rising edge                                 |
// |            reset asynchronous, active-high                                 |
// |            bus   uart_rx_if.master (rx_line in; data, rx_valid, rx_busy,   |
// |                  frame_err and optionally parity_err out)                  |
// | Macro    : UART_RX_PARITY_EN - adds PARITY state and parity_err output     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       clk,
   input  logic       reset,
   uart_rx_if.master  bus
);

   localparam int CLKS_PER_BIT = uart_clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
   localparam logic [2:0]  IDX_LAST  = 3'(UART_DATA_BITS - 1);

   if ((CLKS_PER_BIT < 4) || (CLKS_PER_BIT > 65535)) begin : g_cfg_check
      $error("uart_rx: clks_per_bit out of range 4..65535");
   end

   logic rx_s;

   uart_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (bus.rx_line),
      .q_o   (rx_s)
   );

   uart_state_e               state_q;
   logic [15:0]               clk_count_q;
   logic [2:0]                bit_index_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic [UART_DATA_BITS-1:0] data_q;
   logic                      rx_prev_q;
   logic                      rx_valid_q;
   logic                      rx_busy_q;
   logic                      frame_err_q;
`ifdef UART_RX_PARITY_EN
   logic                      parity_bit_q;
   logic                      parity_err_q;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         clk_count_q  <= '0;
         bit_index_q  <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         rx_prev_q    <= 1'b1;
         rx_valid_q   <= 1'b0;
         rx_busy_q    <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bit_q <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         rx_prev_q   <= rx_s;
         // Strobes are single-cycle: cleared every cycle unless set below
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               rx_busy_q <= 1'b0;
               // Only a true high-to-low transition starts a frame, so a
               // line held low (break) cannot retrigger.
               if (rx_prev_q && !rx_s) begin
                  state_q     <= START;
                  clk_count_q <= '0;
                  rx_busy_q   <= 1'b1;
               end
            end

            START: begin
               if (clk_count_q == HALF_LAST) begin
                  clk_count_q <= '0;
                  if (!rx_s) begin
                     state_q     <= DATA;
                     bit_index_q <= '0;
                  end else begin
                     // Line was high again at mid start bit: glitch
                     state_q   <= IDLE;
                     rx_busy_q <= 1'b0;
                  end
               end else begin
                  clk_count_q <= clk_count_q + 16'd1;
               end
            end

            DATA: begin
               if (clk_count_q == BIT_LAST) begin
                  clk_count_q <= '0;
                  // LSB arrives first, so shift right inserting at the MSB
                  shift_q     <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                  bit_index_q <= bit_index_q + 3'd1;
                  if (bit_index_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= STOP;
`endif
                  end
               end else begin
                  clk_count_q <= clk_count_q + 16'd1;
               end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (clk_count_q == BIT_LAST) begin
                  clk_count_q  <= '0;
                  parity_bit_q <= rx_s;
                  state_q      <= STOP;
               end else begin
                  clk_count_q <= clk_count_q + 16'd1;
               end
            end
`endif

            STOP: begin
               // Return to IDLE at mid stop bit so a start edge right at the
               // stop/start boundary of a back-to-back frame is caught.
               if (clk_count_q == BIT_LAST) begin
                  clk_count_q <= '0;
                  state_q     <= IDLE;
                  rx_busy_q   <= 1'b0;
                  if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                     // Even parity: data bits XOR parity bit must be 0
                     if ((^shift_q) ^ parity_bit_q) begin
                        parity_err_q <= 1'b1;
                     end else begin
                        data_q     <= shift_q;
                        rx_valid_q <= 1'b1;
                     end
`else
                     data_q     <= shift_q;
                     rx_valid_q <= 1'b1;
`endif
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end else begin
                  clk_count_q <= clk_count_q + 16'd1;
               end
            end

            default: begin
               state_q   <= IDLE;
               rx_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data       = data_q;
   assign bus.rx_valid   = rx_valid_q;
   assign bus.rx_busy    = rx_busy_q;
   assign bus.frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_rx                                                      |
// | Purpose  : Directed self-checking bench for uart_rx at 10 clocks per bit.  |
// |            Parity cases are included when UART_RX_PARITY_EN is defined.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_uart_rx;

   localparam int CPB = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   uart_rx_if bus ();

   uart_rx #(
      .CLK_FREQ  (1000000),
      .BAUD_RATE (100000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc++;

   // Event monitor: counts strobes and busy rises, logs received bytes
   int         nvalid = 0;
   int         nferr  = 0;
   int         nboth  = 0;
   int         nbusy_rise = 0;
   int         valid_cyc  = 0;
   logic [7:0] data_log [0:63];
   logic       busy_prev = 1'b0;
`ifdef UART_RX_PARITY_EN
   int         nperr = 0;
`endif

   always @(negedge clk) begin
      if (reset) begin
         busy_prev = 1'b0;
      end else begin
         if (bus.rx_valid) begin
            if (nvalid < 64) data_log[nvalid] = bus.data;
            nvalid++;
            valid_cyc = cyc;
         end
         if (bus.frame_err) nferr++;
         if (bus.rx_valid && bus.frame_err) nboth++;
`ifdef UART_RX_PARITY_EN
         if (bus.parity_err) nperr++;
`endif
         if (bus.rx_busy && !busy_prev) nbusy_rise++;
         busy_prev = bus.rx_busy;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   int start_cyc = 0;

   task automatic send_bit(input logic v);
      bus.rx_line = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stopb,
                             input logic usepar, input logic parb);
      start_cyc = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      if (usepar) send_bit(parb);
      send_bit(stopb);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int         v0, f0, b0, base, lat;
   logic [7:0] b33;

   initial begin
      reset       = 1'b1;
      bus.rx_line = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_data",  32'(bus.data), 32'h00);
      chk("rst_valid", 32'(bus.rx_valid), 32'h0);
      chk("rst_busy",  32'(bus.rx_busy), 32'h0);
      chk("rst_ferr",  32'(bus.frame_err), 32'h0);
      reset = 1'b0;
      repeat (20) @(negedge clk);

      // Good frame 0xA5
      v0 = nvalid; f0 = nferr;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      chk("a5_data",   32'(bus.data), 32'hA5);
      chk("a5_nvalid", 32'(nvalid - v0), 32'd1);
      chk("a5_nferr",  32'(nferr - f0), 32'd0);
      chk("a5_busy",   32'(bus.rx_busy), 32'h0);
      lat = valid_cyc - start_cyc - 1;
      chk("a5_latency", 32'((lat >= 96) && (lat <= 98)), 32'd1);

      // 3-cycle low glitch on idle line
      v0 = nvalid; f0 = nferr; b0 = nbusy_rise;
      bus.rx_line = 1'b0;
      repeat (3) @(negedge clk);
      bus.rx_line = 1'b1;
      repeat (30) @(negedge clk);
      chk("gl_busyrise", 32'(nbusy_rise - b0), 32'd1);
      chk("gl_busy",     32'(bus.rx_busy), 32'h0);
      chk("gl_nvalid",   32'(nvalid - v0), 32'd0);
      chk("gl_nferr",    32'(nferr - f0), 32'd0);
      chk("gl_data",     32'(bus.data), 32'hA5);

      // 0x3C with low stop bit, then line held low for 50 bit-times
      v0 = nvalid; f0 = nferr;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      b0 = nbusy_rise;
      repeat (50 * CPB) @(negedge clk);
      chk("fe_nferr",    32'(nferr - f0), 32'd1);
      chk("fe_nvalid",   32'(nvalid - v0), 32'd0);
      chk("fe_data",     32'(bus.data), 32'hA5);
      chk("brk_busyrise", 32'(nbusy_rise - b0), 32'd0);
      chk("brk_busy",    32'(bus.rx_busy), 32'h0);
      bus.rx_line = 1'b1;
      repeat (30) @(negedge clk);
      v0 = nvalid;
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      chk("5a_data",   32'(bus.data), 32'h5A);
      chk("5a_nvalid", 32'(nvalid - v0), 32'd1);

      // Back-to-back 0x00 then 0xFF, no idle gap
      base = nvalid;
      send_frame(8'h00, 1'b1, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
      repeat (30) @(negedge clk);
      chk("b2b_nvalid", 32'(nvalid - base), 32'd2);
      chk("b2b_first",  32'(data_log[base]), 32'h00);
      chk("b2b_second", 32'(data_log[base + 1]), 32'hFF);

      // Reset asserted during data bit 4 of 0x33, held to end of frame
      v0 = nvalid;
      b33 = 8'h33;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(b33[i]);
      bus.rx_line = b33[4];
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mr_data",  32'(bus.data), 32'h00);
      chk("mr_valid", 32'(bus.rx_valid), 32'h0);
      chk("mr_busy",  32'(bus.rx_busy), 32'h0);
      chk("mr_ferr",  32'(bus.frame_err), 32'h0);
      repeat (CPB - 6) @(negedge clk);
      for (int i = 5; i < 8; i++) send_bit(b33[i]);
      send_bit(1'b1);
      repeat (10) @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      chk("mr_nostrobe", 32'(nvalid - v0), 32'd0);
      v0 = nvalid;
      send_frame(8'h81, 1'b1, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      chk("81_data",   32'(bus.data), 32'h81);
      chk("81_nvalid", 32'(nvalid - v0), 32'd1);

`ifdef UART_RX_PARITY_EN
      // Even parity: 0x07 has three ones, parity bit 1 is correct
      v0 = nvalid; f0 = nperr;
      send_frame(8'h07, 1'b1, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      chk("par_ok_nvalid", 32'(nvalid - v0), 32'd1);
      chk("par_ok_data",   32'(bus.data), 32'h07);
      chk("par_ok_nperr",  32'(nperr - f0), 32'd0);
      v0 = nvalid; f0 = nperr;
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      chk("par_bad_nperr",  32'(nperr - f0), 32'd1);
      chk("par_bad_nvalid", 32'(nvalid - v0), 32'd0);
      chk("par_bad_data",   32'(bus.data), 32'h07);
`endif

      chk("valid_ferr_overlap", 32'(nboth), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver; the downstream consumer of the UART transmitter's serial line.
- Frame format: 8N1, LSB first.
- Synchronises the line, detects and validates the start bit, samples each bit at mid-bit, checks the stop bit.
- Presents each received byte with a one-cycle valid strobe to the host-side logic.

Parameters:
- clk_freq, 50000000, system clock frequency in Hz.
- baud_rate, 9600, serial bit rate.
- Derived localparam clks_per_bit = clk_freq/baud_rate. Legal range is 4..65535; out-of-range values are a compile-time error.
- Derived localparam half_bit = clks_per_bit/2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_line  input  1  serial input, idle high, asynchronous to clk.
- data  output  8  last correctly received byte.
- rx_valid  output  1  one-cycle pulse; data updated in the same cycle.
- rx_busy  output  1  high while a frame is in progress.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset (async, active-high): data=0, rx_valid=0, rx_busy=0, frame_err=0, synchroniser flops=1, state=IDLE, counters=0.
- Reset mid-frame aborts the frame; no strobe is produced.
- Synchroniser: rx_line passes through 2 flops to give rx_s. A third flop gives rx_prev for edge detection.
- Counters: clk_count is 16 bits; bit_index is 3 bits.
- IDLE:
  - rx_busy=0.
  - A start is detected only on a falling edge (rx_prev=1, rx_s=0). Go to START with clk_count=0.
  - A line held low, e.g. a break, never retriggers.
- START:
  - Count to half_bit-1, then sample rx_s.
  - If rx_s=0: go to DATA, clk_count=0, bit_index=0.
  - If rx_s=1: this is a glitch; return to IDLE with no strobe.
- DATA:
  - At clk_count=clks_per_bit-1, sample rx_s and shift it in at the MSB of the shift register (shift right). Reset clk_count and increment bit_index.
  - After bit_index=7 is sampled, go to STOP.
- STOP: at clk_count=clks_per_bit-1, sample rx_s.
  - If 1: data<=shift register and rx_valid=1 for exactly one cycle.
  - If 0: frame_err=1 for one cycle; data holds its old value.
  - Either way, go to IDLE.
- rx_busy=1 in START, DATA and STOP.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge at the stop/start boundary is caught.
- Latency: rx_valid rises 2 + half_bit + 9*clks_per_bit (±1) cycles after the pin's falling edge.
- Sampling tolerance: at least ±4% baud mismatch is accepted when clks_per_bit ≥ 16.
- rx_valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - The frame is 8E1.
  - A PARITY state sits between DATA and STOP and samples one bit at full bit-time.
  - An extra port is added: parity_err  output  1, a one-cycle pulse at stop-bit time when the XOR of the 8 data bits and the parity bit is 1.
  - On a parity error, rx_valid is suppressed and data holds its old value.
  - frame_err takes priority; parity_err is not pulsed in a frame that also has a framing error.
- When undefined: no PARITY state and no parity_err port; the block behaves exactly as 8N1 above.

Decomposition:
- Package uart_pkg holds:
  - state encoding constants IDLE/START/DATA/PARITY/STOP (3-bit);
  - UART_DATA_BITS=8;
  - a clks-per-bit computation function shared with the transmitter.
- Sub-module uart_sync2: two-flop synchroniser.
  - Async active-high reset to 1.
  - Reusable by other clock-crossing inputs.

Test Plan:
- Use clk_freq=1000000 and baud_rate=100000, giving clks_per_bit=10 and half_bit=5.
- Drive frame 0xA5 with a correct stop bit -> data=0xA5, exactly one rx_valid pulse, frame_err stays 0, rx_busy returns to 0.
- Low glitch of 3 cycles on an idle line -> rx_busy goes high then returns to 0 before the DATA state is reached, no rx_valid, no frame_err, data unchanged.
- Frame 0x3C with stop bit low, then line held low for 50 bit-times, then released and frame 0x5A sent:
  - the 0x3C frame -> one frame_err pulse, data stays 0xA5, no rx_valid;
  - the held-low period -> no activity;
  - the 0x5A frame -> data=0x5A with one rx_valid.
- Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses, data sequence 0x00 then 0xFF.
- Assert reset during data bit 4 of frame 0x33, then release and send 0x81:
  - during reset -> all outputs 0;
  - for the 0x33 frame -> no strobe;
  - for the 0x81 frame -> data=0x81 with one rx_valid.
- UART_RX_PARITY_EN defined:
  - 0x07 with parity bit 1 -> rx_valid, data=0x07;
  - 0x07 with parity bit 0 -> one parity_err pulse, no rx_valid.
